// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: accepts an 8-bit score over a valid/ready handshake, converts
// it to BCD with shift-and-add-3 and drives a 4-digit multiplexed,
// active-low 7-segment display.
//
// Parameters:
//   SCAN_DIV     clk_100Hz cycles each digit slot is held (1..255)
// Ports:
//   clk_100Hz    sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   score_in     [7:0] unsigned score to display
//   score_valid  score_in offered, held stable until accepted
//   score_ready  block can accept a score this cycle (IDLE)
//   busy         binary-to-BCD conversion in progress (CONV)
//   a_to_g       [6:0] active-low segments, bit6=a .. bit0=g
//   an           [3:0] active-low one-hot digit enable, an[0]=units
// Build option:
//   SEG_BLINK_EN defined -> a changed committed value blinks the display for
//   a 64-cycle window (blank during window cycles 16..31 and 48..63).
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic       clk_100Hz,
  input  logic       rst_n,
  input  logic [7:0] score_in,
  input  logic       score_valid,
  output logic       score_ready,
  output logic       busy,
  output logic [6:0] a_to_g,
  output logic [3:0] an
);

  localparam int unsigned BinW  = 8;
  localparam int unsigned BcdW  = 12;
  localparam int unsigned CntW  = 3;
  localparam int unsigned DivW  = 8;
  localparam int unsigned IdxW  = 2;
  localparam logic [6:0]  SegBl = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [BinW-1:0]   bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BcdW-1:0]   disp_q, disp_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic              load_c;
  logic              shift_c;
  logic              commit_c;
  logic [BcdW-1:0]   adj_c;
  logic [BcdW+BinW-1:0] sh_c;
  logic [6:0]        seg_c;
  logic [3:0]        an_c;

  // State register
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (score_valid) state_d = CONV;
      CONV:    if (cnt_q == CntW'(7)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    score_ready = 1'b0;
    busy        = 1'b0;
    load_c      = 1'b0;
    shift_c     = 1'b0;
    commit_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        score_ready = 1'b1;
        load_c      = score_valid;
      end
      CONV: begin
        busy    = 1'b1;
        shift_c = 1'b1;
      end
      COMMIT:  commit_c = 1'b1;
      default: ;
    endcase
  end

  // Shift-and-add-3: correct each BCD nibble >= 5 before the left shift
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[n*4 +: 4] >= 4'd5) adj_c[n*4 +: 4] = 4'(bcd_q[n*4 +: 4] + 4'd3);
      else                         adj_c[n*4 +: 4] = bcd_q[n*4 +: 4];
    end
    sh_c = {adj_c, bin_q} << 1;
  end

  // Conversion and display register next-state
  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    if (load_c) begin
      bin_d = score_in;
      bcd_d = '0;
      cnt_d = '0;
    end else if (shift_c) begin
      bcd_d = sh_c[BcdW+BinW-1:BinW];
      bin_d = sh_c[BinW-1:0];
      cnt_d = CntW'(cnt_q + CntW'(1));
    end
    // Display only ever sees a finished conversion
    if (commit_c) disp_d = bcd_q;
  end

  // Digit scan divider, free-running
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (div_q == DivW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = IdxW'(idx_q + IdxW'(1));
    end else begin
      div_d = DivW'(div_q + DivW'(1));
    end
  end

  // Datapath registers
  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
      div_q  <= '0;
      idx_q  <= '0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      disp_q <= disp_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SegBl;
    endcase
    return s;
  endfunction

  // Digit mux with leading-zero blanking
  always_comb begin
    seg_c = SegBl;
    unique case (idx_q)
      2'd0: seg_c = seg7(disp_q[3:0]);
      2'd1: seg_c = (disp_q[11:4] == 8'd0) ? SegBl : seg7(disp_q[7:4]);
      2'd2: seg_c = (disp_q[11:8] == 4'd0) ? SegBl : seg7(disp_q[11:8]);
      default: seg_c = SegBl;
    endcase
  end

`ifdef SEG_BLINK_EN
  logic [5:0] blink_cnt_q, blink_cnt_d;
  logic       blink_act_q, blink_act_d;

  // Blink window: restarted by any commit that changes the shown value
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_act_d = blink_act_q;
    if (blink_act_q) begin
      blink_cnt_d = 6'(blink_cnt_q + 6'd1);
      if (blink_cnt_q == 6'd63) blink_act_d = 1'b0;
    end
    if (commit_c && (bcd_q != disp_q)) begin
      blink_cnt_d = '0;
      blink_act_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      blink_act_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_act_q <= blink_act_d;
    end
  end

  // Window cycles 16..31 and 48..63 have count bit 4 set
  always_comb begin
    an_c = ~(4'(4'b0001 << idx_q));
    if (blink_act_q && blink_cnt_q[4]) an_c = 4'b1111;
  end
`else
  always_comb an_c = ~(4'(4'b0001 << idx_q));
`endif

  assign a_to_g = seg_c;
  assign an     = an_c;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (SCAN_DIV=1); blink checks compile only
// when SEG_BLINK_EN is defined.
module tb_seg_scan_ctrl;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] BL = 7'b1111111;

  logic       clk_100Hz = 1'b0;
  logic       rst_n;
  logic [7:0] score_in;
  logic       score_valid;
  logic       score_ready;
  logic       busy;
  logic [6:0] a_to_g;
  logic [3:0] an;

  int vectors     = 0;
  int miscompares = 0;
  logic [1:0] eidx;

  seg_scan_ctrl #(.SCAN_DIV(1)) dut (
    .clk_100Hz  (clk_100Hz),
    .rst_n      (rst_n),
    .score_in   (score_in),
    .score_valid(score_valid),
    .score_ready(score_ready),
    .busy       (busy),
    .a_to_g     (a_to_g),
    .an         (an)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  // Expected digit index: advances every edge with SCAN_DIV=1
  always @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) eidx <= 2'd0;
    else        eidx <= eidx + 2'd1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] an_exp(input logic [1:0] i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  // Sample one full scan (4 cycles) and check every digit
  task automatic show(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
    logic [6:0] exp;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_100Hz);
      case (eidx)
        2'd0: exp = u;
        2'd1: exp = t;
        2'd2: exp = h;
        default: exp = BL;
      endcase
      chk("an", 7'(an), 7'(an_exp(eidx)));
      chk("seg", a_to_g, exp);
    end
  endtask

  // Transfer one score and check the handshake timing through COMMIT
  task automatic send(input logic [7:0] v);
    @(negedge clk_100Hz);
    chk("ready_pre", 7'(score_ready), 7'd1);
    score_in    = v;
    score_valid = 1'b1;
    @(negedge clk_100Hz);
    score_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk_100Hz);
      chk("busy_conv", 7'(busy), 7'd1);
      chk("ready_conv", 7'(score_ready), 7'd0);
    end
    @(negedge clk_100Hz);
    chk("busy_commit", 7'(busy), 7'd0);
    chk("ready_commit", 7'(score_ready), 7'd0);
    @(negedge clk_100Hz);
    chk("ready_idle", 7'(score_ready), 7'd1);
    chk("busy_idle", 7'(busy), 7'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    score_in    = 8'd0;
    score_valid = 1'b0;
    repeat (2) @(negedge clk_100Hz);
    chk("rst_ready", 7'(score_ready), 7'd1);
    chk("rst_busy", 7'(busy), 7'd0);
    chk("rst_an", 7'(an), 7'(4'b1110));
    chk("rst_seg", a_to_g, S0);
    rst_n = 1'b1;

    // Idle scan: "0" with leading blanks
    show(S0, BL, BL);
    show(S0, BL, BL);

    send(8'd255);
    show(S5, S5, S2);

    send(8'd100);
    show(S0, S0, S1);
    send(8'd7);
    show(S7, BL, BL);

    // 42 offered during conversion of 13 must wait for score_ready
    @(negedge clk_100Hz);
    score_in    = 8'd13;
    score_valid = 1'b1;
    @(negedge clk_100Hz);
    score_in = 8'd42;
    chk("hold_busy", 7'(busy), 7'd1);
    repeat (9) @(negedge clk_100Hz);
    chk("hold_ready", 7'(score_ready), 7'd1);
    show(S3, S1, BL);
    chk("hold_busy42", 7'(busy), 7'd1);
    score_valid = 1'b0;
    repeat (7) @(negedge clk_100Hz);
    chk("after42_ready", 7'(score_ready), 7'd1);
    show(S2, S4, BL);

    // Reset in the middle of converting 200
    @(negedge clk_100Hz);
    score_in    = 8'd200;
    score_valid = 1'b1;
    @(negedge clk_100Hz);
    score_valid = 1'b0;
    repeat (3) @(negedge clk_100Hz);
    rst_n = 1'b0;
    #1;
    chk("abort_an", 7'(an), 7'(4'b1110));
    chk("abort_seg", a_to_g, S0);
    chk("abort_ready", 7'(score_ready), 7'd1);
    chk("abort_busy", 7'(busy), 7'd0);
    @(negedge clk_100Hz);
    rst_n = 1'b1;
    repeat (12) @(negedge clk_100Hz);
    show(S0, BL, BL);

    // Transfer on the first edge after reset release is not lost
    rst_n = 1'b0;
    @(negedge clk_100Hz);
    rst_n       = 1'b1;
    score_in    = 8'd7;
    score_valid = 1'b1;
    @(negedge clk_100Hz);
    score_valid = 1'b0;
    chk("rel_busy", 7'(busy), 7'd1);
    repeat (9) @(negedge clk_100Hz);
    show(S7, BL, BL);

`ifdef SEG_BLINK_EN
    // Commit 9 after 0: blanks in window cycles 16..31 and 48..63
    rst_n = 1'b0;
    @(negedge clk_100Hz);
    rst_n = 1'b1;
    send(8'd9);
    for (int k = 1; k < 72; k++) begin
      @(negedge clk_100Hz);
      if ((k >= 16 && k <= 31) || (k >= 48 && k <= 63))
        chk("blink_an", 7'(an), 7'(4'b1111));
      else
        chk("blink_an", 7'(an), 7'(an_exp(eidx)));
    end
    send(8'd9);
    for (int k = 1; k < 72; k++) begin
      @(negedge clk_100Hz);
      chk("noblink_an", 7'(an), 7'(an_exp(eidx)));
    end
    show(S9, BL, BL);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1, clk_100Hz cycles each digit slot is held (legal 1..255).
REQ-002 clk_100Hz  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 score_in  input  8  unsigned binary score to display (0..255).
REQ-005 score_valid  input  1  score_in offered; held with score_in stable until accepted.
REQ-006 score_ready  output  1  block can accept a score this cycle.
REQ-007 busy  output  1  binary-to-BCD conversion in progress.
REQ-008 a_to_g  output  7  segment drive, active-low, bit6=a .. bit0=g.
REQ-009 an  output  4  digit enables, active-low, one-hot; an[0]=units, an[3]=leftmost.

Function
REQ-010 Control FSM SHALL have states IDLE, CONV, COMMIT; score_ready=1 only in IDLE, busy=1 only in CONV.
REQ-011 Transfer occurs on a rising edge with score_valid=1 and score_ready=1: score_in captured, FSM IDLE->CONV.
REQ-012 CONV SHALL run exactly 8 cycles of shift-and-add-3 (add 3 to any BCD nibble >=5 before each left shift) on a 12-bit BCD / 8-bit binary register.
REQ-013 After 8 CONV cycles FSM -> COMMIT for 1 cycle, loading the 3-nibble display register, then -> IDLE.
REQ-014 Latency: transfer at edge N -> display register holds new value after edge N+9; next transfer possible at edge N+10.
REQ-015 score_valid while score_ready=0 SHALL be ignored; in-flight conversion and display register unaffected.
REQ-016 Scan: 2-bit digit index and 8-bit divider; index advances 0->1->2->3->0 every SCAN_DIV cycles, wrapping 3->0; runs independent of FSM.
REQ-017 an SHALL be ~(1<<index); exactly one bit low at all times.
REQ-018 Digit 3 SHALL always be blank (a_to_g=1111111).
REQ-019 Hundreds blank when 0; tens blank when hundreds and tens both 0; units always shown.
REQ-020 Encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; blank=1111111.
REQ-021 Display register changes only in COMMIT, so digits never show a partial conversion.

Reset
REQ-022 rst_n low SHALL immediately force: FSM IDLE, display register 0, conversion registers 0, index 0, divider 0.
REQ-023 Output values during and after reset: score_ready=1, busy=0, an=1110, a_to_g=0000001.
REQ-024 Reset during CONV SHALL abort conversion; no COMMIT occurs; display returns to "0".
REQ-025 Release of rst_n SHALL take effect on the first rising edge of clk_100Hz after deassertion; no transfer on that edge is lost if score_valid=1.

Configuration
REQ-026 Macro SEG_BLINK_EN defined: on each COMMIT whose value differs from the previous display value, a 64-cycle blink window starts; within it, all an=1111 during cycles 16..31 and 48..63 of the window; a new differing COMMIT restarts the window.
REQ-027 SEG_BLINK_EN undefined: no blink logic or counter exists; an follows REQ-017 unconditionally.
REQ-028 Port list and all other behaviour SHALL be identical in both builds.

Verification
REQ-029 Reset, then idle 8 cycles, SCAN_DIV=1 -> an cycles 1110,1101,1011,0111 repeatedly; a_to_g 0000001, blank, blank, blank.
REQ-030 Send 255 at edge N -> busy=1 edges N..N+8, score_ready=0 until N+9; afterwards digits units=5 (0100100), tens=5, hundreds=2 (0010010), digit3 blank.
REQ-031 Send 100 then 7 -> "100" shows tens 0000001; then "7" shows units 0001111, tens and hundreds blank.
REQ-032 Assert score_valid with 42 during CONV of 13 -> ignored; display 13; 42 accepted only once score_ready=1, then displayed 42.
REQ-033 Assert rst_n low at CONV cycle 4 of 200 -> an=1110, a_to_g=0000001 immediately; after release display stays 0.
REQ-034 SEG_BLINK_EN build: commit 9 after 0 -> an=1111 for window cycles 16..31 and 48..63; recommit 9 -> no blink.
